// File: rtl/irq_pkg.sv
// Shared constants and types for the parametrised interrupt controller.
package irq_pkg;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_ENABLE  = 2'd1;
    localparam logic [1:0] REG_MODE    = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    localparam logic [31:0] DEFAULT_CAUSE_BASE = 32'h8000_0010;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StService
    } irq_state_e;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module irq_prio_enc #(
    parameter int unsigned N    = 8,
    parameter int unsigned ID_W = 3
) (
    input  logic [N-1:0]    req,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    always_comb begin
        valid = 1'b0;
        id    = '0;
        // Scan downwards so the lowest requesting index is the last one assigned.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller_n.sv
// Parametrised interrupt controller: edge/level sources, fixed priority, ack/done handshake
// towards the CPU, and a small register file reached through the memory-mapped bus.
module irq_controller_n
    import irq_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 8,
    parameter int unsigned ID_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    parameter logic [31:0] CAUSE_BASE = DEFAULT_CAUSE_BASE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               reg_we,
    input  logic [1:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    input  logic               int_ack,
    input  logic               int_done,
    output logic               INT,
    output logic [31:0]        cause
);

    irq_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] prev_src_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] mode_q, mode_d;
    logic [ID_W-1:0]    cur_id_q, cur_id_d;
    logic [ID_W-1:0]    active_id_q, active_id_d;
    logic [31:0]        cause_q, cause_d;

    logic [NUM_SRC-1:0] src_edge;
    logic [NUM_SRC-1:0] w1c;
    logic [NUM_SRC-1:0] ack_clr;
    logic               ack_take;
    logic               cand_valid;
    logic [ID_W-1:0]    cand_id;
    logic               in_service;

    logic unused_wdata;
    assign unused_wdata = ^reg_wdata[31:NUM_SRC];

    assign src_edge   = irq_src & ~prev_src_q;
    assign in_service = (state_q == StService);
    assign INT        = (state_q == StReq);
    assign cause      = cause_q;

    irq_prio_enc #(
        .N    (NUM_SRC),
        .ID_W (ID_W)
    ) u_prio_enc (
        .req   (pending_q & enable_q),
        .valid (cand_valid),
        .id    (cand_id)
    );

    // Handshake FSM; cause tracks the best candidate until the CPU acknowledges it.
    always_comb begin
        state_d     = state_q;
        cur_id_d    = cur_id_q;
        active_id_d = active_id_q;
        cause_d     = cause_q;
        ack_take    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cand_valid) begin
                    state_d  = StReq;
                    cur_id_d = cand_id;
                    cause_d  = CAUSE_BASE + 32'(cand_id);
                end
            end
            StReq: begin
                if (int_ack) begin
                    state_d     = StService;
                    active_id_d = cur_id_q;
                    ack_take    = 1'b1;
                end else if (cand_valid) begin
                    cur_id_d = cand_id;
                    cause_d  = CAUSE_BASE + 32'(cand_id);
                end else begin
                    state_d = StIdle;
                end
            end
            StService: begin
                if (int_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        w1c      = '0;
        enable_d = enable_q;
        mode_d   = mode_q;
        if (reg_we) begin
            unique case (reg_addr)
                REG_PENDING: w1c      = reg_wdata[NUM_SRC-1:0];
                REG_ENABLE:  enable_d = reg_wdata[NUM_SRC-1:0];
                REG_MODE:    mode_d   = reg_wdata[NUM_SRC-1:0];
                REG_STATUS:  ;
            endcase
        end
    end

    // A fresh edge beats a simultaneous W1C or ack clear; level sources simply mirror the line.
    always_comb begin
        ack_clr   = '0;
        pending_d = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            ack_clr[i] = ack_take && (cur_id_q == ID_W'(i));
            if (mode_q[i]) begin
                pending_d[i] = (pending_q[i] & ~w1c[i] & ~ack_clr[i]) | src_edge[i];
            end else begin
                pending_d[i] = irq_src[i];
            end
        end
    end

    always_comb begin
        reg_rdata = '0;
        unique case (reg_addr)
            REG_PENDING: reg_rdata[NUM_SRC-1:0] = pending_q;
            REG_ENABLE:  reg_rdata[NUM_SRC-1:0] = enable_q;
            REG_MODE:    reg_rdata[NUM_SRC-1:0] = mode_q;
            REG_STATUS: begin
                reg_rdata[31]       = in_service;
                reg_rdata[ID_W-1:0] = active_id_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // Track the lines during reset so sources already high at release are not edges.
            prev_src_q  <= irq_src;
            state_q     <= StIdle;
            pending_q   <= '0;
            enable_q    <= '0;
            mode_q      <= '1;
            cur_id_q    <= '0;
            active_id_q <= '0;
            cause_q     <= '0;
        end else begin
            prev_src_q  <= irq_src;
            state_q     <= state_d;
            pending_q   <= pending_d;
            enable_q    <= enable_d;
            mode_q      <= mode_d;
            cur_id_q    <= cur_id_d;
            active_id_q <= active_id_d;
            cause_q     <= cause_d;
        end
    end

endmodule
